// File: rtl/bank_access_sequencer_pkg.sv
// Shared eDRAM definitions: bank geometry, sequencer state encoding and default
// timing, shared between the access sequencer and the power management unit.
package bank_access_sequencer_pkg;

    localparam int unsigned NUM_BANKS           = 16;
    localparam int unsigned BANK_W              = 4;
    localparam int unsigned WAKE_CNT_W          = 10;
    localparam int unsigned ACC_CNT_W           = 4;
    localparam int unsigned T_ACCESS_CYCLES_DEF = 4;
    localparam int unsigned T_WAKE_TIMEOUT_DEF  = 1023;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAKE,
        ST_ACCESS,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/bank_access_sequencer_if.sv
// Host request/response channel of the bank access sequencer.
interface bank_access_sequencer_if #(
    parameter int unsigned ADDR_W = 14
);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic              rsp_valid;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_we,
        input  req_ready, rsp_valid, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we,
        output req_ready, rsp_valid, rsp_err
    );

endinterface

// File: rtl/bank_access_sequencer.sv
// Sequences a single host access into one eDRAM bank: wakes the bank through the
// power manager, drives the array command window and reports completion.
module bank_access_sequencer
    import bank_access_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W          = 14,
    parameter int unsigned T_ACCESS_CYCLES = T_ACCESS_CYCLES_DEF,
    parameter int unsigned T_WAKE_TIMEOUT  = T_WAKE_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bank_access_sequencer_if.slave   host,
    input  logic [NUM_BANKS-1:0]     bank_active_status,
    output logic [NUM_BANKS-1:0]     request_wakeup,
    output logic [NUM_BANKS-1:0]     access_done,
    output logic                     bank_cmd_valid,
    output logic [BANK_W-1:0]        bank_sel,
    output logic [ADDR_W-BANK_W-1:0] bank_row_addr,
    output logic                     bank_cmd_we
);

    localparam int unsigned ROW_W = ADDR_W - BANK_W;
    localparam logic [ACC_CNT_W-1:0]  ACC_LAST  = ACC_CNT_W'(T_ACCESS_CYCLES - 1);
    localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(T_WAKE_TIMEOUT - 1);

    seq_state_t              r_state;
    logic [WAKE_CNT_W-1:0]   r_wake_cnt;
    logic [ACC_CNT_W-1:0]    r_acc_cnt;
    logic                    r_req_ready;
    logic [NUM_BANKS-1:0]    r_wakeup;
    logic [NUM_BANKS-1:0]    r_done;
    logic                    r_cmd_valid;
    logic [BANK_W-1:0]       r_bank_sel;
    logic [ROW_W-1:0]        r_row;
    logic                    r_we;
    logic                    r_rsp_valid;
    logic                    r_rsp_err;

    logic                    w_hs;
    logic                    w_bank_active;
    logic [BANK_W-1:0]       w_req_bank;
    logic [NUM_BANKS-1:0]    w_req_onehot;
    logic [NUM_BANKS-1:0]    w_sel_onehot;

    assign w_hs          = host.req_valid && r_req_ready;
    assign w_bank_active = bank_active_status[r_bank_sel];
    assign w_req_bank    = host.req_addr[ADDR_W-1 -: BANK_W];
    assign w_req_onehot  = NUM_BANKS'(1) << w_req_bank;
    assign w_sel_onehot  = NUM_BANKS'(1) << r_bank_sel;

    // Wake counter compares against TIMEOUT-1 before incrementing, so the error
    // response lands exactly T_WAKE_TIMEOUT cycles after WAKE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wake_cnt  <= '0;
            r_acc_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_wakeup    <= '0;
            r_done      <= '0;
            r_cmd_valid <= 1'b0;
            r_bank_sel  <= '0;
            r_row       <= '0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_done      <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_state     <= ST_WAKE;
                        r_req_ready <= 1'b0;
                        r_bank_sel  <= w_req_bank;
                        r_row       <= host.req_addr[ROW_W-1:0];
                        r_we        <= host.req_we;
                        r_wake_cnt  <= '0;
                        r_wakeup    <= w_req_onehot;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (w_bank_active) begin
                        r_state     <= ST_ACCESS;
                        r_acc_cnt   <= '0;
                        r_cmd_valid <= 1'b1;
                    end else if (r_wake_cnt == WAKE_LAST) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_wakeup    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end else if (r_wake_cnt != '1) begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (!w_bank_active) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                        r_cmd_valid <= 1'b0;
                        r_wakeup    <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                    end else if (r_acc_cnt == ACC_LAST) begin
                        r_state     <= ST_DONE;
                        r_cmd_valid <= 1'b0;
                        r_wakeup    <= '0;
                        r_done      <= w_sel_onehot;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign host.req_ready = r_req_ready;
    assign host.rsp_valid = r_rsp_valid;
    assign host.rsp_err   = r_rsp_err;
    assign request_wakeup = r_wakeup;
    assign access_done    = r_done;
    assign bank_cmd_valid = r_cmd_valid;
    assign bank_sel       = r_bank_sel;
    assign bank_row_addr  = r_row;
    assign bank_cmd_we    = r_we;

endmodule

// File: tb/tb_bank_access_sequencer.sv
// Directed bench for bank_access_sequencer with a timestamp-based reference model
// compared every cycle, plus literal timing expectations per scenario.
module tb_bank_access_sequencer;

    localparam int TA = 4;
    localparam int TW = 1023;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] status = '0;
    logic [15:0] request_wakeup;
    logic [15:0] access_done;
    logic        bank_cmd_valid;
    logic [3:0]  bank_sel;
    logic [9:0]  bank_row_addr;
    logic        bank_cmd_we;

    bank_access_sequencer_if #(.ADDR_W(14)) host_if ();

    bank_access_sequencer #(
        .ADDR_W         (14),
        .T_ACCESS_CYCLES(TA),
        .T_WAKE_TIMEOUT (TW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .host              (host_if),
        .bank_active_status(status),
        .request_wakeup    (request_wakeup),
        .access_done       (access_done),
        .bank_cmd_valid    (bank_cmd_valid),
        .bank_sel          (bank_sel),
        .bank_row_addr     (bank_row_addr),
        .bank_cmd_we       (bank_cmd_we)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the outstanding request by the edge numbers of its
    // handshake and of the first access cycle rather than by an FSM state.
    int         m_edge    = 0;
    bit         m_live    = 0;
    bit         m_busy    = 0;
    bit         m_in_done = 0;
    bit         m_rsp     = 0;
    bit         m_err     = 0;
    int         m_act     = -1;
    int         m_hs      = 0;
    int         m_bank    = 0;
    int         m_row     = 0;
    bit         m_we      = 0;
    int         hs_log[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, m_edge);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live = 0; m_busy = 0; m_in_done = 0; m_rsp = 0; m_err = 0;
            m_act = -1; m_bank = 0; m_row = 0; m_we = 0;
        end else begin
            m_edge++;
            m_rsp = 0;
            m_err = 0;
            if (m_in_done) begin
                m_in_done = 0;
            end else if (!m_busy) begin
                if (host_if.req_valid && m_live) begin
                    m_busy = 1;
                    m_hs   = m_edge;
                    m_act  = -1;
                    m_bank = int'(host_if.req_addr) / 1024;
                    m_row  = int'(host_if.req_addr) % 1024;
                    m_we   = host_if.req_we;
                    hs_log.push_back(m_edge);
                end
            end else if (m_act < 0) begin
                if (status[m_bank]) m_act = m_edge;
                else if (m_edge - m_hs == TW) begin
                    m_busy = 0; m_rsp = 1; m_err = 1;
                end
            end else begin
                if (!status[m_bank]) begin
                    m_busy = 0; m_rsp = 1; m_err = 1; m_act = -1;
                end else if (m_edge - m_act == TA) begin
                    m_busy = 0; m_in_done = 1; m_rsp = 1; m_act = -1;
                end
            end
            m_live = 1;
        end
    end

    always @(negedge clk) begin
        chk("req_ready", {31'd0, host_if.req_ready}, {31'd0, m_live && !m_busy && !m_in_done});
        chk("request_wakeup", {16'd0, request_wakeup}, m_busy ? (32'd1 << m_bank) : 32'd0);
        chk("access_done", {16'd0, access_done}, m_in_done ? (32'd1 << m_bank) : 32'd0);
        chk("bank_cmd_valid", {31'd0, bank_cmd_valid}, {31'd0, m_busy && (m_act >= 0)});
        chk("rsp_valid", {31'd0, host_if.rsp_valid}, {31'd0, m_rsp});
        chk("rsp_err", {31'd0, host_if.rsp_err}, {31'd0, m_err});
        chk("bank_sel", {28'd0, bank_sel}, 32'(m_bank));
        chk("bank_row_addr", {22'd0, bank_row_addr}, 32'(m_row));
        chk("bank_cmd_we", {31'd0, bank_cmd_we}, {31'd0, m_we});
    end

    int          mon_cmd = 0, mon_wake_only = 0, mon_done = 0, mon_rsp = 0, mon_err = 0;
    int          mon_rsp_edge = 0, mon_done_edge = 0;
    logic [15:0] mon_done_vec = '0;

    always @(negedge clk) begin
        if (bank_cmd_valid) mon_cmd++;
        if (request_wakeup != 16'd0 && !bank_cmd_valid) mon_wake_only++;
        if (access_done != 16'd0) begin
            mon_done++;
            mon_done_vec  = access_done;
            mon_done_edge = m_edge;
        end
        if (host_if.rsp_valid) begin
            mon_rsp++;
            if (host_if.rsp_err) mon_err++;
            mon_rsp_edge = m_edge;
        end
    end

    int b_cmd, b_wake, b_done, b_rsp, b_err;

    task automatic snap();
        b_cmd = mon_cmd; b_wake = mon_wake_only; b_done = mon_done; b_rsp = mon_rsp; b_err = mon_err;
    endtask

    function automatic logic [13:0] mk_addr(input logic [3:0] b, input logic [9:0] r);
        return {b, r};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!host_if.req_ready && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (!host_if.req_ready) chk("ready_wait", {31'd0, host_if.req_ready}, 32'd1);
    endtask

    task automatic do_req(input logic [13:0] a, input logic w, output int hs);
        wait_ready();
        host_if.req_valid = 1'b1;
        host_if.req_addr  = a;
        host_if.req_we    = w;
        @(posedge clk); #1;
        hs = m_edge;
        host_if.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int base, input int limit);
        int n = 0;
        while (mon_rsp <= base && n < limit) begin
            @(posedge clk); #1; n++;
        end
        if (mon_rsp <= base) chk("rsp_wait", 32'(mon_rsp), 32'(base + 1));
    endtask

    initial begin
        int hs, hs1, hs2, base_hs, n;
        host_if.req_valid = 1'b0;
        host_if.req_addr  = '0;
        host_if.req_we    = 1'b0;

        // Reset values and first ready edge
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ready", {31'd0, host_if.req_ready}, 32'd0);
        chk("rst_wakeup", {16'd0, request_wakeup}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", {31'd0, host_if.req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_after_edge", {31'd0, host_if.req_ready}, 32'd1);

        // Bank 3 already active, write
        status = 16'h0008;
        snap();
        do_req(mk_addr(4'd3, 10'h010), 1'b1, hs);
        wait_rsp(b_rsp, 40);
        chk("b3_sel", {28'd0, bank_sel}, 32'd3);
        chk("b3_row", {22'd0, bank_row_addr}, 32'h010);
        chk("b3_we", {31'd0, bank_cmd_we}, 32'd1);
        chk("b3_cmd_cycles", 32'(mon_cmd - b_cmd), 32'd4);
        chk("b3_done_edge", 32'(mon_done_edge - hs), 32'd5);
        chk("b3_done_vec", {16'd0, mon_done_vec}, 32'h0008);
        chk("b3_err", 32'(mon_err - b_err), 32'd0);

        // Bank 7 asleep, becomes active after 60 wake cycles
        status = 16'h0000;
        wait_ready();
        snap();
        do_req(mk_addr(4'd7, 10'h2bc), 1'b0, hs);
        repeat (59) @(posedge clk);
        #1 status = 16'h0080;
        wait_rsp(b_rsp, 40);
        chk("b7_wake_cycles", 32'(mon_wake_only - b_wake), 32'd60);
        chk("b7_done_count", 32'(mon_done - b_done), 32'd1);
        chk("b7_done_vec", {16'd0, mon_done_vec}, 32'h0080);
        chk("b7_err", 32'(mon_err - b_err), 32'd0);

        // Wake timeout
        status = 16'h0000;
        wait_ready();
        snap();
        do_req(mk_addr(4'd5, 10'h000), 1'b0, hs);
        wait_rsp(b_rsp, 1100);
        chk("to_latency", 32'(mon_rsp_edge - hs), 32'd1023);
        chk("to_err", 32'(mon_err - b_err), 32'd1);
        chk("to_done", 32'(mon_done - b_done), 32'd0);
        chk("to_wakeup_after", {16'd0, request_wakeup}, 32'd0);

        // Status drops in the second access cycle
        status = 16'h0004;
        wait_ready();
        snap();
        do_req(mk_addr(4'd2, 10'h0ab), 1'b1, hs);
        @(posedge clk); #1;
        @(posedge clk); #1;
        status = 16'h0000;
        wait_rsp(b_rsp, 40);
        chk("ab_rsp_edge", 32'(mon_rsp_edge - hs), 32'd3);
        chk("ab_cmd_cycles", 32'(mon_cmd - b_cmd), 32'd2);
        chk("ab_err", 32'(mon_err - b_err), 32'd1);
        chk("ab_done", 32'(mon_done - b_done), 32'd0);
        chk("ab_cmd_low", {31'd0, bank_cmd_valid}, 32'd0);

        // Reset in the middle of an access
        status = 16'h0200;
        wait_ready();
        snap();
        do_req(mk_addr(4'd9, 10'h123), 1'b0, hs);
        @(posedge clk); #1;
        chk("rr_in_access", {31'd0, bank_cmd_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_wakeup", {16'd0, request_wakeup}, 32'd0);
        chk("rr_done", {16'd0, access_done}, 32'd0);
        chk("rr_cmd", {31'd0, bank_cmd_valid}, 32'd0);
        chk("rr_rsp", {30'd0, host_if.rsp_valid, host_if.rsp_err}, 32'd0);
        chk("rr_latched", {17'd0, bank_sel, bank_row_addr, bank_cmd_we}, 32'd0);
        chk("rr_ready", {31'd0, host_if.req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk("rr_ready_pre", {31'd0, host_if.req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rr_ready_post", {31'd0, host_if.req_ready}, 32'd1);
        chk("rr_no_rsp", 32'(mon_rsp - b_rsp), 32'd0);
        chk("rr_no_done", 32'(mon_done - b_done), 32'd0);

        // Back-to-back requests with req_valid held high
        status = 16'h0012;
        wait_ready();
        snap();
        base_hs = hs_log.size();
        host_if.req_valid = 1'b1;
        host_if.req_addr  = mk_addr(4'd1, 10'h111);
        host_if.req_we    = 1'b0;
        @(posedge clk); #1;
        hs1 = m_edge;
        chk("bb_first_accept", 32'(hs_log.size() - base_hs), 32'd1);
        host_if.req_addr = mk_addr(4'd4, 10'h222);
        host_if.req_we   = 1'b1;
        n = 0;
        while (hs_log.size() <= base_hs + 1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        hs2 = (hs_log.size() > base_hs + 1) ? hs_log[$] : hs1;
        host_if.req_valid = 1'b0;
        chk("bb_gap", 32'(hs2 - hs1), 32'd7);
        wait_rsp(b_rsp + 1, 50);
        repeat (3) @(posedge clk);
        #1;
        chk("bb_rsp_count", 32'(mon_rsp - b_rsp), 32'd2);
        chk("bb_done_count", 32'(mon_done - b_done), 32'd2);
        chk("bb_err", 32'(mon_err - b_err), 32'd0);
        chk("bb_sel", {28'd0, bank_sel}, 32'd4);
        chk("bb_done_vec", {16'd0, mon_done_vec}, 32'h0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bank_access_sequencer.md
BANK_ACCESS_SEQUENCER -- requirements
Module: bank_access_sequencer

Interface
REQ-001 Parameter ADDR_W, default 14, meaning word address width, 16384 words of 64 bits = 1 Mb.
REQ-002 Parameter T_ACCESS_CYCLES, default 4, meaning array access duration in cycles, legal range 1..15.
REQ-003 Parameter T_WAKE_TIMEOUT, default 1023, meaning maximum cycles to wait for the bank to become active.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  host request valid.
REQ-007 req_ready  output  1  sequencer can accept a request.
REQ-008 req_addr  input  ADDR_W  word address; bits [ADDR_W-1:ADDR_W-4] select the bank.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 bank_active_status  input  16  per-bank ACTIVE indication from the power manager.
REQ-011 request_wakeup  output  16  per-bank wake/keep-alive request to the power manager.
REQ-012 access_done  output  16  per-bank one-cycle completion pulse to the power manager.
REQ-013 bank_cmd_valid  output  1  array command strobe, high for the whole access window.
REQ-014 bank_sel  output  4  latched bank index.
REQ-015 bank_row_addr  output  ADDR_W-4  latched in-bank address.
REQ-016 bank_cmd_we  output  1  latched write enable.
REQ-017 rsp_valid  output  1  one-cycle response pulse, issued once per accepted request.
REQ-018 rsp_err  output  1  qualifies rsp_valid; 1 = timeout or abort.

Function
REQ-019 The FSM SHALL use the states IDLE, WAKE, ACCESS and DONE.
REQ-020 req_ready SHALL be 1 only in IDLE; a handshake is req_valid && req_ready.
REQ-021 On handshake, the sequencer SHALL latch addr and we and go to WAKE; bank_sel, bank_row_addr and bank_cmd_we SHALL hold until the next handshake.
REQ-022 request_wakeup[bank_sel] SHALL be 1 in WAKE and ACCESS; all other bits SHALL be 0, and all bits SHALL be 0 in IDLE and DONE.
REQ-023 In WAKE: if bank_active_status[bank_sel]=1, the next state SHALL be ACCESS with the access counter cleared.
REQ-024 In WAKE: otherwise the wake counter SHALL increment; when it equals T_WAKE_TIMEOUT, the sequencer SHALL pulse rsp_valid=1 with rsp_err=1 and go to IDLE, without any access_done.
REQ-025 In ACCESS, bank_cmd_valid SHALL be 1 for exactly T_ACCESS_CYCLES cycles, after which the next state SHALL be DONE.
REQ-026 In ACCESS, if bank_active_status[bank_sel] drops to 0, the sequencer SHALL abort: bank_cmd_valid=0 from the next cycle, rsp_valid=1 with rsp_err=1, next state IDLE, no access_done.
REQ-027 DONE SHALL last one cycle with access_done[bank_sel]=1, rsp_valid=1, rsp_err=0 and request_wakeup all 0; the next state SHALL be IDLE.
REQ-028 Latency with the bank already active: handshake at edge k, WAKE at cycle k+1, ACCESS at k+2..k+1+T_ACCESS_CYCLES, DONE at the following cycle, then req_ready=1 in the cycle after DONE.
REQ-029 The wake counter SHALL be 10 bits, saturating, and cleared on entry to WAKE; the access counter SHALL be 4 bits.
REQ-030 At most one request SHALL be outstanding; req_valid outside IDLE SHALL be ignored.
REQ-031 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-032 When rst_n=0 the sequencer SHALL enter IDLE immediately, regardless of clk.
REQ-033 Under reset, the outputs SHALL be: request_wakeup=0, access_done=0, bank_cmd_valid=0, rsp_valid=0, rsp_err=0, bank_sel=0, bank_row_addr=0, bank_cmd_we=0, req_ready=0.
REQ-034 req_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-035 A reset during an operation SHALL discard the operation with no rsp_valid and no access_done.

Structure
REQ-036 A shared eDRAM package SHALL hold NUM_BANKS=16, BANK_W=4, the state enum and the default timing constants, shared with the power management unit.
REQ-037 The block SHALL be a single module with no sub-module; the bank one-hot decode SHALL be inline.

Verification
REQ-038 Bank 3 active, write to addr 0x3010 -> bank_sel=3, row=0x010, bank_cmd_valid high 4 cycles, access_done[3] pulse at cycle k+6, rsp_err=0.
REQ-039 Bank 7 sleeping, status rises 60 cycles after the request -> request_wakeup[7] held for those 60 cycles, then a normal access, a single access_done[7] and rsp_err=0.
REQ-040 Status held at 0 -> rsp_valid with rsp_err=1 exactly 1023 cycles after entering WAKE, request_wakeup all 0 the next cycle, no access_done.
REQ-041 Status drops in the 2nd ACCESS cycle -> bank_cmd_valid low the next cycle, rsp_err=1, no access_done.
REQ-042 rst_n asserted in ACCESS -> all outputs 0 immediately, no rsp_valid; req_ready=1 one cycle after release.
REQ-043 Back-to-back requests with req_valid held high -> the second is accepted in the cycle after DONE, each request produces exactly one rsp_valid.
